// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory between the CPU and the loader/debug port.
// Grant one cycle after a request edge, read data the cycle after the grant; requesters hold req until granted.
module mem_arbiter #(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 8,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [AWIDTH-1:0] cpu_addr,
    input  logic [DWIDTH-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DWIDTH-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_wr,
    input  logic [AWIDTH-1:0] ldr_addr,
    input  logic [DWIDTH-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DWIDTH-1:0] ldr_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        G_CPU = 2'd1,
        G_LDR = 2'd2
    } state_t;

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX - 1);

    state_t          state_q, state_d;
    logic            last_ldr_q, last_ldr_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            cpu_rvalid_q, cpu_rvalid_d;
    logic            ldr_rvalid_q, ldr_rvalid_d;
    logic            cpu_at_limit;

    // The CPU only forces the loader off once it has waited through LOCK_MAX locked grants.
    assign cpu_at_limit = cpu_req && (lock_cnt_q == CNT_MAX);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req && ldr_req) begin
                    state_d = last_ldr_q ? G_CPU : G_LDR;
                end else if (cpu_req) begin
                    state_d = G_CPU;
                end else if (ldr_req) begin
                    state_d = G_LDR;
                end
            end
            G_CPU: begin
                state_d = ldr_req ? G_LDR : IDLE;
            end
            G_LDR: begin
                if (ldr_lock && ldr_req && !cpu_at_limit) begin
                    state_d = G_LDR;
                end else if (cpu_req) begin
                    state_d = G_CPU;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lock_cnt_d = '0;
        if (state_q == G_LDR && state_d == G_LDR && cpu_req) begin
            lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + CW'(1);
        end
    end

    always_comb begin
        last_ldr_d = last_ldr_q;
        if (state_q == G_CPU) begin
            last_ldr_d = 1'b0;
        end else if (state_q == G_LDR) begin
            last_ldr_d = 1'b1;
        end
    end

    assign cpu_gnt = (state_q == G_CPU);
    assign ldr_gnt = (state_q == G_LDR);

    assign mem_rd    = (cpu_gnt && !cpu_wr) || (ldr_gnt && !ldr_wr);
    assign mem_wr    = (cpu_gnt && cpu_wr) || (ldr_gnt && ldr_wr);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (ldr_gnt ? ldr_addr  : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (ldr_gnt ? ldr_wdata : '0);

    // The return flag follows whoever issued the read, regardless of the current owner.
    assign cpu_rvalid_d = cpu_gnt && !cpu_wr;
    assign ldr_rvalid_d = ldr_gnt && !ldr_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_ldr_q   <= 1'b1;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            ldr_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_ldr_q   <= last_ldr_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            ldr_rvalid_q <= ldr_rvalid_d;
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign ldr_rvalid = ldr_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? mem_rdata : '0;
    assign ldr_rdata  = ldr_rvalid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed phases plus random traffic, with a reference memory and per-cycle monitor.
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int LM = 8;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ldr_req, ldr_wr, ldr_lock, ldr_gnt, ldr_rvalid;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata, ldr_rdata;
    logic          mem_rd, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        return (i == 5) ? 8'hA3 : 8'(i * 37 + 11);
    endfunction

    // Synchronous memory attached to the DUT; request captured mid-cycle, applied at the edge.
    logic [7:0] ram [0:31];
    logic       s_rd, s_wr;
    logic [4:0] s_a;
    logic [7:0] s_d;
    initial begin
        for (int i = 0; i < 32; i++) ram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            s_rd = mem_rd; s_wr = mem_wr; s_a = mem_addr; s_d = mem_wdata;
            @(posedge clk);
            if (s_rd) mem_rdata = ram[s_a];
            if (s_wr) ram[s_a] = s_d;
        end
    end

    // Monitor: reference memory in grant order, expected read data queues, per-cycle rules.
    logic [7:0] refmem [0:31];
    logic [7:0] cpu_exp_q [$];
    logic [7:0] ldr_exp_q [$];
    logic [7:0] mon_exp;
    logic       cpu_rd_prev, ldr_rd_prev, prev_cpu_gnt;
    int         lock_run;
    string      trace = "";

    initial begin
        for (int i = 0; i < 32; i++) refmem[i] = init_val(i);
        cpu_rd_prev = 0; ldr_rd_prev = 0; prev_cpu_gnt = 0; lock_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cpu_exp_q.delete(); ldr_exp_q.delete();
                cpu_rd_prev = 0; ldr_rd_prev = 0; prev_cpu_gnt = 0; lock_run = 0;
            end else begin
                if (cpu_gnt) trace = {trace, "C"};
                else if (ldr_gnt) trace = {trace, "L"};
                else trace = {trace, "-"};

                check("gnt_exclusive", {cpu_gnt, ldr_gnt}, {1'b0, 1'b0} | {1'b0, ldr_gnt & ~cpu_gnt} | {cpu_gnt & ~ldr_gnt, 1'b0});
                check("cpu_rvalid_timing", cpu_rvalid, cpu_rd_prev);
                check("ldr_rvalid_timing", ldr_rvalid, ldr_rd_prev);

                if (cpu_rvalid) begin
                    if (cpu_exp_q.size() == 0) check("cpu_rdata_unexpected", 1, 0);
                    else begin mon_exp = cpu_exp_q.pop_front(); check("cpu_rdata", cpu_rdata, mon_exp); end
                end else check("cpu_rdata_idle", cpu_rdata, 0);
                if (ldr_rvalid) begin
                    if (ldr_exp_q.size() == 0) check("ldr_rdata_unexpected", 1, 0);
                    else begin mon_exp = ldr_exp_q.pop_front(); check("ldr_rdata", ldr_rdata, mon_exp); end
                end else check("ldr_rdata_idle", ldr_rdata, 0);

                if (cpu_gnt) begin
                    check("cpu_back_to_back", prev_cpu_gnt, 0);
                    check("cpu_mem_ctl", {mem_rd, mem_wr, mem_addr}, {~cpu_wr, cpu_wr, cpu_addr});
                    if (cpu_wr) begin
                        check("cpu_mem_wdata", mem_wdata, cpu_wdata);
                        refmem[cpu_addr] = cpu_wdata;
                    end else cpu_exp_q.push_back(refmem[cpu_addr]);
                end else if (ldr_gnt) begin
                    check("ldr_mem_ctl", {mem_rd, mem_wr, mem_addr}, {~ldr_wr, ldr_wr, ldr_addr});
                    if (ldr_wr) begin
                        check("ldr_mem_wdata", mem_wdata, ldr_wdata);
                        refmem[ldr_addr] = ldr_wdata;
                    end else ldr_exp_q.push_back(refmem[ldr_addr]);
                end else begin
                    check("idle_mem", {mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
                end

                // Loader grants while the CPU is kept waiting must never exceed the lock limit.
                if (ldr_gnt && cpu_req) begin
                    lock_run++;
                    check("lock_bound", lock_run <= LM, 1);
                end else lock_run = 0;

                cpu_rd_prev  = cpu_gnt & ~cpu_wr;
                ldr_rd_prev  = ldr_gnt & ~ldr_wr;
                prev_cpu_gnt = cpu_gnt;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic cpu_access(input logic wr, input logic [4:0] addr, input logic [7:0] data);
        int waited = 0;
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = data;
        do begin
            @(negedge clk);
            waited++;
        end while (!cpu_gnt && waited < 200);
        check("cpu_wait", waited <= LM + 4, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    // mode: 0 read, 1 write, 2 random direction per access.
    task automatic ldr_burst(input int n, input int mode, input logic lock,
                             input logic [4:0] base, input logic [7:0] dbase);
        for (int i = 0; i < n; i++) begin
            int waited = 0;
            ldr_req   = 1'b1;
            ldr_wr    = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
            ldr_addr  = base + 5'(i);
            ldr_wdata = dbase + 8'(i);
            ldr_lock  = lock && (i < n - 1);
            do begin
                @(negedge clk);
                waited++;
            end while (!ldr_gnt && waited < 200);
            check("ldr_wait", waited <= LM + 4, 1);
            @(posedge clk); #1;
        end
        ldr_req = 1'b0; ldr_wr = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    int    st;
    string exp_s;

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_wr = 0; ldr_addr = '0; ldr_wdata = '0; ldr_lock = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with both requesting; CPU must win the first tie afterwards.
        st = trace.len();
        fork
            cpu_access(1'b0, 5'd1, 8'd0);
            ldr_burst(1, 0, 1'b0, 5'd2, 8'd0);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("reset_outputs",
                          {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_rdata, ldr_rdata,
                           mem_rd, mem_wr, mem_addr, mem_wdata}, 0);
                end
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        check_str("first_grant", trace.substr(st, st + 2), "-CL");

        // Single CPU read: grant one cycle after request, data the cycle after.
        idle(3);
        st = trace.len();
        cpu_access(1'b0, 5'd5, 8'd0);
        @(negedge clk);
        check("cpu_read_return", {cpu_rvalid, cpu_rdata, ldr_rvalid, ldr_rdata, ldr_gnt},
              {1'b1, 8'hA3, 1'b0, 8'h00, 1'b0});
        check_str("cpu_read_latency", trace.substr(st, st + 1), "-C");
        @(posedge clk); #1;

        // Continuous unlocked contention: strict alternation, loader first since CPU went last.
        idle(3);
        st = trace.len();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    cpu_access(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
            end
            ldr_burst(10, 2, 1'b0, 5'($urandom), 8'($urandom));
        join
        exp_s = "-";
        for (int i = 0; i < 10; i++) exp_s = {exp_s, "LC"};
        check_str("contention", trace.substr(st, st + 20), exp_s);

        // Locked write burst with the CPU waiting from the start.
        idle(3);
        st = trace.len();
        fork
            ldr_burst(12, 1, 1'b1, 5'd0, 8'h10);
            cpu_access(1'b0, 5'd3, 8'd0);
        join
        check_str("locked_burst", trace.substr(st, st + 13), "-LLLLLLLLCLLLL");
        idle(2);
        for (int i = 0; i < 12; i++) check("burst_mem", ram[i], 8'h10 + 8'(i));

        // Lock with no CPU demand is unbounded.
        idle(3);
        st = trace.len();
        ldr_burst(20, 0, 1'b1, 5'($urandom), 8'd0);
        exp_s = "-";
        for (int i = 0; i < 20; i++) exp_s = {exp_s, "L"};
        check_str("lock_alone", trace.substr(st, st + 20), exp_s);

        // Reset during a CPU read grant cancels the pending return.
        idle(3);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 5'd7;
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        check("rst_mid_grant", {cpu_gnt, mem_rd}, 2'b11);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_abort", {cpu_rvalid, cpu_rdata, cpu_gnt, ldr_gnt, mem_rd, mem_wr}, 0);
        @(negedge clk);
        check("rst_idle", {cpu_gnt, ldr_gnt, ldr_rvalid, cpu_rvalid}, 0);
        @(posedge clk); #1;
        st = trace.len();
        fork
            cpu_access(1'b1, 5'd9, 8'h5C);
            ldr_burst(1, 0, 1'b0, 5'd9, 8'd0);
        join
        check_str("post_reset_tie", trace.substr(st, st + 2), "-CL");

        // Random traffic: gaps, random directions, random locked bursts.
        idle(3);
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    cpu_access(1'($urandom_range(0, 1)), 5'($urandom), 8'($urandom));
                end
            end
            begin
                repeat (15) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ldr_burst(int'($urandom_range(1, 12)), 2, 1'($urandom_range(0, 1)),
                              5'($urandom), 8'($urandom));
                end
            end
        join
        idle(4);
        check("cpu_queue_drained", cpu_exp_q.size(), 0);
        check("ldr_queue_drained", ldr_exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares the processor's one data/instruction memory between the CPU controller and a program-loader/debug port. It sits between the two requesters and the synchronous memory: it arbitrates round-robin, steers address/write-data/strobes to the memory, and returns read data with a valid flag to the winner. A lock input lets the loader run bounded back-to-back bursts.

## Interface
- AWIDTH, 5, memory address width
- DWIDTH, 8, memory data width
- LOCK_MAX, 8, maximum consecutive locked loader grants while the CPU is waiting (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  AWIDTH  CPU address
- cpu_wdata  in  DWIDTH  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  cpu_rdata valid (cycle after a CPU read grant)
- cpu_rdata  out  DWIDTH  read data to CPU
- ldr_req, ldr_wr, ldr_addr, ldr_wdata  in  1/1/AWIDTH/DWIDTH  loader equivalents
- ldr_lock  in  1  loader requests to keep the bus after the current grant
- ldr_gnt, ldr_rvalid, ldr_rdata  out  1/1/DWIDTH  loader equivalents
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AWIDTH  memory address
- mem_wdata  out  DWIDTH  memory write data
- mem_rdata  in  DWIDTH  memory read data, valid the cycle after mem_rd

## Operation
- FSM states: IDLE, G_CPU, G_LDR. cpu_gnt = (state==G_CPU), ldr_gnt = (state==G_LDR), decoded from registered state.
- Grant cycle: exactly one access; mem_addr/mem_wdata muxed from the granted requester; mem_rd = gnt & ~wr, mem_wr = gnt & wr. In IDLE: mem_rd = mem_wr = 0, mem_addr/mem_wdata = 0.
- Requester holds req/wr/addr/wdata stable until it samples its gnt high at a rising edge, then drops req (or, loader under lock, presents next access).
- `last` register = last served requester; reset value LDR (CPU wins first tie).
- IDLE: both req → grant the one ≠ last; one req → grant it; none → stay.
- After G_CPU: ldr_req → G_LDR; else IDLE. cpu_req at this edge is ignored (stale).
- After G_LDR: if ldr_lock & ldr_req & ~(cpu_req & lock_cnt==LOCK_MAX-1) → G_LDR again; else cpu_req → G_CPU; else IDLE. Stale ldr_req ignored when lock low.
- lock_cnt: increments per consecutive G_LDR→G_LDR transition while cpu_req high, clears on any other transition or when cpu_req low; saturates at LOCK_MAX-1.
- Read return: rvalid registered = gnt & ~wr of previous cycle; rdata = mem_rdata passthrough, 0 when rvalid low.
- `last` updates on every grant cycle.

## Timing
- Reset (rst high at an edge): state IDLE, last=LDR, lock_cnt=0, cpu_gnt=ldr_gnt=0, cpu_rvalid=ldr_rvalid=0, rdata outputs 0, mem_rd=mem_wr=0, mem_addr=mem_wdata=0. Reset mid-grant aborts; rvalid for an in-flight read is suppressed.
- Latency from IDLE: req high at edge N → gnt high in cycle N+1 → rvalid/rdata in cycle N+2.
- Single requester, unlocked: max one access per 2 cycles.
- Both requesting continuously, no lock: strict alternation, one access per cycle.
- Loader locked with CPU waiting: at most LOCK_MAX consecutive loader grants, then CPU granted next cycle; lock without CPU request is unbounded.
- Write and read data never overlap ownership: rvalid pulse goes to the requester of the read even if the other holds the grant that cycle.

## Test plan
- Reset: hold rst 2 cycles with both req high → all outputs 0; first grant after release is CPU.
- CPU read: mem[5]=0xA3, cpu_req/addr=5 at edge N → cpu_gnt, mem_rd, mem_addr=5 in N+1; cpu_rvalid, cpu_rdata=0xA3 in N+2; ldr outputs 0.
- Contention: both req continuously, unlocked → grants CPU,LDR,CPU,LDR… every cycle, no idle cycles, no cycle with both gnts.
- Locked burst: ldr writes 0x10..0x1B to addr 0..11 with lock, cpu_req high from start, LOCK_MAX=8 → 8 ldr_gnt, then cpu_gnt, then loader resumes; memory contents correct.
- Lock alone: ldr_lock with cpu_req low for 20 accesses → 20 consecutive ldr_gnt cycles.
- Reset mid-read: rst asserted in CPU read grant cycle → no cpu_rvalid following; state IDLE.
